// File: rtl/sw_debounce_pkg.sv
// Shared constants and state encoding for the switch debouncer.
package sw_debounce_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES     = 4;
  localparam int N_CHANNELS              = 8;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;
endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter and edge pulses.
module debounce_ch
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt, cnt_n;
  db_state_e        st, st_n;
  logic             db_n, rise_n, fall_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      st    <= ST_STABLE;
      cnt   <= '0;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      st    <= st_n;
      cnt   <= cnt_n;
      db    <= db_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // In STABLE cnt is always 0, and DEBOUNCE_CYCLES >= 2, so the first
  // mismatch can never complete the count on its own.
  always_comb begin
    st_n   = ST_STABLE;
    cnt_n  = '0;
    db_n   = db;
    rise_n = 1'b0;
    fall_n = 1'b0;
    unique case (st)
      ST_STABLE: begin
        if (sync2 != db) begin
          st_n  = ST_PENDING;
          cnt_n = CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (sync2 != db) begin
          if (cnt == CNT_MAX) begin
            db_n   = sync2;
            rise_n = sync2;
            fall_n = ~sync2;
          end else begin
            st_n  = ST_PENDING;
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/sw_debounce8.sv
// N-channel switch debouncer. Downstream quad XOR wiring: sw_db[2k] = a(k+1),
// sw_db[2k+1] = b(k+1) for k = 0..3.
module sw_debounce8
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int N               = N_CHANNELS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw_in[i]),
      .db   (sw_db[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
endmodule

// File: tb/tb_sw_debounce8.sv
// Directed bench for sw_debounce8 at DEBOUNCE_CYCLES = 4 (update on edge 6).
module tb_sw_debounce8;
  import sw_debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw_in = 8'h00;
  logic [7:0] sw_db, rise, fall;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rise5_cnt;

  sw_debounce8 #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES), .N(N_CHANNELS)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_in (sw_in),
    .sw_db (sw_db),
    .rise  (rise),
    .fall  (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset with all switches high
    sw_in = 8'hFF;
    rst   = 1'b1;
    step(3);
    chk("rst_db",   {24'd0, sw_db}, 32'h00);
    chk("rst_rise", {24'd0, rise},  32'h00);
    chk("rst_fall", {24'd0, fall},  32'h00);
    rst = 1'b0;
    step(5);
    chk("rel_db_e5",   {24'd0, sw_db}, 32'h00);
    chk("rel_rise_e5", {24'd0, rise},  32'h00);
    step(1);
    chk("rel_db_e6",   {24'd0, sw_db}, 32'hFF);
    chk("rel_rise_e6", {24'd0, rise},  32'hFF);
    step(1);
    chk("rel_rise_e7", {24'd0, rise},  32'h00);

    // Return all low: fall on every channel at edge 6
    sw_in = 8'h00;
    step(6);
    chk("all_fall", {24'd0, fall},  32'hFF);
    chk("all_low",  {24'd0, sw_db}, 32'h00);
    step(2);

    // Clean edge on bit 0
    sw_in = 8'h01;
    step(5);
    chk("clean_db_e5", {24'd0, sw_db}, 32'h00);
    step(1);
    chk("clean_db_e6",   {24'd0, sw_db}, 32'h01);
    chk("clean_rise_e6", {24'd0, rise},  32'h01);
    step(1);
    chk("clean_rise_e7", {24'd0, rise},  32'h00);
    chk("clean_db_e7",   {24'd0, sw_db}, 32'h01);

    // Glitch on bit 3: high 3 cycles (longest rejectable), then low
    sw_in = 8'h09;
    step(3);
    sw_in = 8'h01;
    for (int i = 0; i < 10; i++) begin
      chk("glitch_b3", {29'd0, sw_db[3], rise[3], fall[3]}, 32'h0);
      step(1);
    end
    chk("glitch_db", {24'd0, sw_db}, 32'h01);

    // Bounce on bit 5: 2 high, 2 low, for 20 cycles, then settle high
    rise5_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sw_in[5] = ((i / 2) % 2 == 0);
      step(1);
      if (rise[5]) rise5_cnt++;
    end
    chk("bounce_no_rise", rise5_cnt, 0);
    sw_in[5] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (rise[5]) rise5_cnt++;
      if (i == 5) chk("bounce_rise_e5", {31'd0, rise[5]}, 32'd0);
      if (i == 6) chk("bounce_rise_e6", {31'd0, rise[5]}, 32'd1);
    end
    chk("bounce_one_rise", rise5_cnt, 1);
    chk("bounce_db", {24'd0, sw_db}, 32'h21);

    // Simultaneous: 0F -> F0
    sw_in = 8'h0F;
    step(8);
    chk("sim_pre_db", {24'd0, sw_db}, 32'h0F);
    sw_in = 8'hF0;
    step(5);
    chk("sim_db_e5", {24'd0, sw_db}, 32'h0F);
    step(1);
    chk("sim_fall", {24'd0, fall},  32'h0F);
    chk("sim_rise", {24'd0, rise},  32'hF0);
    chk("sim_db",   {24'd0, sw_db}, 32'hF0);
    step(1);
    chk("sim_pulse_clr", {16'd0, rise, fall}, 32'h0);

    // Reset mid-count on bit 1
    sw_in = 8'h00;
    step(8);
    chk("mid_pre_db", {24'd0, sw_db}, 32'h00);
    sw_in = 8'h02;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mid_no_rise", {24'd0, rise}, 32'h00);
    end
    rst = 1'b1;
    step(1);
    chk("mid_rst_db",   {24'd0, sw_db}, 32'h00);
    chk("mid_rst_rise", {24'd0, rise},  32'h00);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk("mid_post_rise", {24'd0, rise}, 32'h00);
    end
    step(1);
    chk("mid_rise_e6", {24'd0, rise},  32'h02);
    chk("mid_db_e6",   {24'd0, sw_db}, 32'h02);
    step(1);
    chk("mid_rise_e7", {24'd0, rise},  32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sw_debounce8.md
SW_DEBOUNCE8 -- requirements
Module: sw_debounce8

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of consecutive stable clock cycles required to accept a new level (10 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter N, default 8, meaning the channel count.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sw_in  input  N  raw, asynchronous board switch levels.
REQ-006 SHALL have port sw_db  output  N  debounced levels.
REQ-007 SHALL have port rise  output  N  one-cycle pulse per channel when sw_db goes 0->1.
REQ-008 SHALL have port fall  output  N  one-cycle pulse per channel when sw_db goes 1->0.
REQ-009 SHALL use this fixed channel map when driving the downstream quad XOR gate: sw_db[2k] = a(k+1), sw_db[2k+1] = b(k+1), for k = 0..3.

Function
REQ-010 SHALL pass each sw_in bit through a two-flop synchronizer; only the second flop's output (sync2) SHALL be used by the debounce logic.
REQ-011 SHALL be, per channel, a two-state machine with states STABLE (sync2 == sw_db, cnt = 0) and PENDING (sync2 != sw_db, cnt counting).
REQ-012 SHALL apply these rules on each edge where sync2 != sw_db:
- if cnt == DEBOUNCE_CYCLES-1: load sw_db <= sync2, clear cnt to 0, assert the matching rise or fall for exactly that one cycle;
- otherwise: increment cnt by 1.
REQ-013 SHALL, on each edge where sync2 == sw_db, clear cnt to 0 and deassert rise and fall.
REQ-014 SHALL give a total latency from a clean raw transition to the sw_db update of exactly DEBOUNCE_CYCLES+2 rising edges. Edge 1 is the first edge that samples the new raw level.
REQ-015 SHALL discard, without any output change or pulse, a raw pulse (glitch) that reverts before the count completes; cnt SHALL restart from 0 on the next mismatch.
REQ-016 SHALL size cnt at $clog2(DEBOUNCE_CYCLES) bits; cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 SHALL keep channels fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-018 SHALL never assert rise and fall together on one channel, and SHALL never assert either in two consecutive cycles on one channel.

Reset
REQ-019 SHALL, while rst = 1, asynchronously force synchronizer flops = 0, cnt = 0, sw_db = 0, rise = 0, fall = 0.
REQ-020 SHALL abort any in-progress count when reset is asserted mid-count; after release, counting SHALL resume from 0 against sw_db = 0.
REQ-021 SHALL treat a switch held high across reset release as a new 0->1 transition, producing one rise pulse DEBOUNCE_CYCLES+2 edges after release.

Structure
REQ-022 SHALL take DEFAULT_DEBOUNCE_CYCLES (1_000_000), SIM_DEBOUNCE_CYCLES (4), and N_CHANNELS (8) from shared package sw_debounce_pkg.
REQ-023 SHALL implement one channel (synchronizer, counter, state, edge pulses) in sub-module debounce_ch, instantiated N times by a generate loop.
REQ-024 SHALL contain no combinational path from sw_in to any output.

Verification (DEBOUNCE_CYCLES = 4)
REQ-025 SHALL check reset: rst pulsed while sw_in = 8'hFF -> all outputs 0 during reset; after release, sw_db = 8'hFF and rise = 8'hFF on the 6th edge, for one cycle only.
REQ-026 SHALL check a clean edge: sw_in[0] 0->1 and held -> sw_db[0] = 1 and rise[0] = 1 on edge 6; rise[0] = 0 on edge 7; the other bits are unchanged.
REQ-027 SHALL check glitch rejection: sw_in[3] high for 3 cycles, then low -> sw_db[3] stays 0, and rise[3] and fall[3] are never asserted.
REQ-028 SHALL check bounce: sw_in[5] toggles every 2 cycles for 20 cycles, then settles high -> exactly one rise[5], 6 edges after settling.
REQ-029 SHALL check simultaneous events: sw_in 8'h0F -> 8'hF0 in one cycle (prior sw_db = 8'h0F) -> on the same edge, fall = 8'h0F, rise = 8'hF0, sw_db = 8'hF0.
REQ-030 SHALL check reset mid-count: sw_in[1] rises, rst pulsed at edge 4 -> no rise[1] before reset; rise[1] occurs 6 edges after release.
